uart_rx_oversample: RTL and testbench

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

---
 rtl/uart_rx_oversample_pkg.sv | 19 +
 rtl/uart_rx_oversample_if.sv | 14 +
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_rx_oversample.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_oversample_pkg.sv
// Shared state encoding, default oversample factor and majority helper
// for the oversampling UART receiver.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Serial-in / parallel-out bundle of the receiver; slave is the receiver side.
interface uart_rx_oversample_if #(parameter int SIZE = 8);

  logic            rx;
  logic [SIZE-1:0] data_out;
  logic            rx_done;
  logic            parity_err;
  logic            frame_err;
  logic            rx_busy;

  modport master (output rx, input data_out, rx_done, parity_err, frame_err, rx_busy);
  modport slave  (input rx, output data_out, rx_done, parity_err, frame_err, rx_busy);

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock sample tick every TICK_DIV clocks;
// clr realigns the phase to a detected start edge.
module uart_baud_tick #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)          r_cnt <= '0;
    else if (r_cnt == LAST)  r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

  // Suppressed while clearing so the first tick after a start is a full period away.
  assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 2-FF synchronizer, 3-sample mid-bit majority vote,
// optional parity, early stop-bit decision for back-to-back frames.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 18432000,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE),
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_rx_oversample_if.slave  bus
);

  if (TICK_DIV < 1 || OVERSAMPLE < 4 || SIZE < 2 || CLK_FREQ < BAUD_RATE) begin : g_bad_cfg
    $error("uart_rx_oversample: illegal parameter combination");
  end

  localparam int            SW     = $clog2(OVERSAMPLE);
  localparam int            BW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(SIZE - 1);

  uart_rx_state_t  r_state, w_next;

  logic [1:0]      r_sync;
  logic            r_rx_prev;
  logic [1:0]      r_vld_pipe;
  logic            r_armed;
  logic [SW-1:0]   r_sub;
  logic [BW-1:0]   r_bit;
  logic [1:0]      r_smp;
  logic [SIZE-1:0] r_shift;
  logic            r_xor;
  logic            r_pbit;
  logic [SIZE-1:0] r_data_out;
  logic            r_rx_done;
  logic            r_parity_err;
  logic            r_frame_err;

  logic w_rx_s, w_tick, w_start_edge, w_mid, w_end, w_maj, w_last_bit;
  logic w_busy, w_clr, w_shift, w_bit_inc, w_pcap, w_load, w_ferr;

  assign w_rx_s       = r_sync[1];
  // Only a genuine high-to-low seen after the line was qualified high counts.
  assign w_start_edge = r_armed & r_rx_prev & ~w_rx_s;
  assign w_mid        = w_tick && (r_sub == S_HI);
  assign w_end        = w_tick && (r_sub == S_LAST);
  assign w_maj        = maj3(r_smp[0], r_smp[1], w_rx_s);
  assign w_last_bit   = (r_bit == B_LAST);

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_edge) w_next = ST_START;
      ST_START:  if (w_mid && w_maj) w_next = ST_IDLE;
                 else if (w_end)     w_next = ST_DATA;
      ST_DATA:   if (w_end && w_last_bit) w_next = PARITY_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_end) w_next = ST_STOP;
      ST_STOP:   if (w_mid) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = 1'b1;
    w_clr     = 1'b0;
    w_shift   = 1'b0;
    w_bit_inc = 1'b0;
    w_pcap    = 1'b0;
    w_load    = 1'b0;
    w_ferr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        w_clr  = w_start_edge;
      end
      ST_DATA: begin
        w_shift   = w_mid;
        w_bit_inc = w_end & ~w_last_bit;
      end
      ST_PARITY: w_pcap = w_mid;
      ST_STOP: begin
        w_load = w_mid &  w_maj;
        w_ferr = w_mid & ~w_maj;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync       <= 2'b11;
      r_rx_prev    <= 1'b1;
      r_vld_pipe   <= '0;
      r_armed      <= 1'b0;
      r_sub        <= '0;
      r_bit        <= '0;
      r_smp        <= '0;
      r_shift      <= '0;
      r_xor        <= 1'b0;
      r_pbit       <= 1'b0;
      r_data_out   <= '0;
      r_rx_done    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], bus.rx};
      r_rx_prev  <= w_rx_s;
      // Synchronizer preset values are not real line data until two clocks after reset.
      r_vld_pipe <= {r_vld_pipe[0], 1'b1};

      if (w_ferr)                        r_armed <= 1'b0;
      else if (w_rx_s && r_vld_pipe[1])  r_armed <= 1'b1;

      if (w_clr) begin
        r_sub <= '0;
        r_bit <= '0;
        r_xor <= 1'b0;
      end else begin
        if (w_tick)    r_sub <= (r_sub == S_LAST) ? '0 : r_sub + 1'b1;
        if (w_bit_inc) r_bit <= r_bit + 1'b1;
        if (w_shift) begin
          r_shift <= {w_maj, r_shift[SIZE-1:1]};
          r_xor   <= r_xor ^ w_maj;
        end
      end

      if (w_tick && r_sub == S_LO)  r_smp[0] <= w_rx_s;
      if (w_tick && r_sub == S_MID) r_smp[1] <= w_rx_s;
      if (w_pcap)                   r_pbit   <= w_maj;

      r_rx_done    <= w_load;
      r_frame_err  <= w_ferr;
      r_parity_err <= w_load & PARITY_EN & (r_pbit != (r_xor ^ PARITY_ODD));
      if (w_load) r_data_out <= r_shift;
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.rx_done    = r_rx_done;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.rx_busy    = w_busy;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench: frames driven onto two receivers (no parity / even parity),
// expected words queued at drive time and popped when rx_done fires.
module tb_uart_rx_oversample;
  import uart_pkg::*;

  localparam int TICK_DIV = 10;
  localparam int OS       = 16;
  localparam int BIT      = TICK_DIV * OS;

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_oversample_if #(.SIZE(8)) bus0 ();
  uart_rx_oversample_if #(.SIZE(8)) bus1 ();

  uart_rx_oversample #(.SIZE(8), .PARITY_EN(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  uart_rx_oversample #(.SIZE(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt0 = 0, done_cnt1 = 0;
  int   ferr_cnt0 = 0, ferr_cnt1 = 0;
  logic done_prev0 = 1'b0, done_prev1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.rx_done) begin
        done_cnt0++;
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          chk("dut0_data", 32'(bus0.data_out), 32'(e0.data));
          chk("dut0_parity_err", 32'(bus0.parity_err), 32'(e0.perr));
        end
        chk("dut0_done_single_cycle", 32'(done_prev0), 0);
        chk("dut0_done_ferr_exclusive", 32'(bus0.frame_err), 0);
      end
      if (bus0.frame_err) ferr_cnt0++;
      if (bus1.rx_done) begin
        done_cnt1++;
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          chk("dut1_data", 32'(bus1.data_out), 32'(e1.data));
          chk("dut1_parity_err", 32'(bus1.parity_err), 32'(e1.perr));
        end
        chk("dut1_done_single_cycle", 32'(done_prev1), 0);
      end
      if (bus1.frame_err) ferr_cnt1++;
    end
    done_prev0 = bus0.rx_done;
    done_prev1 = bus1.rx_done;
  end

  task automatic drive(input int which, input logic v);
    if (which == 0) bus0.rx = v;
    else            bus1.rx = v;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the line at the stop level, so a low stop bit keeps the line low.
  task automatic send_frame(input int which, input logic [7:0] data, input logic par_en,
                            input logic par, input logic stop, input int nbits);
    logic [10:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = data;
    if (par_en) begin
      b[9]  = par;
      b[10] = stop;
    end else begin
      b[9]  = stop;
    end
    for (int i = 0; i < nbits; i++) begin
      drive(which, b[i]);
      wait_clk(BIT);
    end
  endtask

  task automatic wait_sb(input int which);
    int t;
    t = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && t < 4 * BIT) begin
      wait_clk(1);
      t++;
    end
    chk((which == 0) ? "dut0_scoreboard_drain" : "dut1_scoreboard_drain",
        32'((which == 0) ? q0.size() : q1.size()), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.rx = 1'b1;
    bus1.rx = 1'b1;
    rst     = 1'b1;
    wait_clk(5);
    chk("rst_data_out0",   32'(bus0.data_out),   0);
    chk("rst_rx_done0",    32'(bus0.rx_done),    0);
    chk("rst_frame_err0",  32'(bus0.frame_err),  0);
    chk("rst_parity_err0", 32'(bus0.parity_err), 0);
    chk("rst_rx_busy0",    32'(bus0.rx_busy),    0);
    chk("rst_data_out1",   32'(bus1.data_out),   0);
    chk("rst_rx_busy1",    32'(bus1.rx_busy),    0);
    rst = 1'b0;
    wait_clk(20);

    // Plain frame
    q0.push_back('{8'hA5, 1'b0});
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 10);
    wait_clk(BIT);
    wait_sb(0);
    chk("a5_data_out", 32'(bus0.data_out), 32'hA5);
    chk("a5_done_cnt", 32'(done_cnt0), 1);
    chk("a5_ferr_cnt", 32'(ferr_cnt0), 0);

    // Short low glitch: enters START, then rejected as a false start
    drive(0, 1'b0);
    wait_clk(3 * TICK_DIV);
    drive(0, 1'b1);
    wait_clk(5);
    chk("glitch_busy_in_start", 32'(bus0.rx_busy), 1);
    wait_clk(2 * BIT);
    chk("glitch_back_idle", 32'(bus0.rx_busy), 0);
    chk("glitch_done_cnt",  32'(done_cnt0), 1);
    chk("glitch_ferr_cnt",  32'(ferr_cnt0), 0);

    // Good frame then a frame with a low stop bit
    q0.push_back('{8'h11, 1'b0});
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 10);
    wait_clk(BIT);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 10);
    drive(0, 1'b1);
    wait_clk(2 * BIT);
    wait_sb(0);
    chk("ferr_cnt",      32'(ferr_cnt0), 1);
    chk("ferr_done_cnt", 32'(done_cnt0), 2);
    chk("ferr_data_held", 32'(bus0.data_out), 32'h11);

    // Back-to-back frames, no idle between stop and next start
    q0.push_back('{8'h00, 1'b0});
    q0.push_back('{8'hFF, 1'b0});
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 10);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 10);
    wait_clk(BIT);
    wait_sb(0);
    chk("b2b_done_cnt", 32'(done_cnt0), 4);
    chk("b2b_data_out", 32'(bus0.data_out), 32'hFF);

    // Reset in the middle of data bit 4 of 0x5A
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 5);
    drive(0, 1'b1);
    wait_clk(BIT / 2);
    rst = 1'b1;
    wait_clk(3);
    chk("midrst_data_out", 32'(bus0.data_out), 0);
    chk("midrst_busy",     32'(bus0.rx_busy),  0);
    rst = 1'b0;
    wait_clk(2 * BIT);
    chk("midrst_no_done", 32'(done_cnt0), 4);
    chk("midrst_no_ferr", 32'(ferr_cnt0), 1);
    chk("midrst_idle",    32'(bus0.rx_busy), 0);
    q0.push_back('{8'hC3, 1'b0});
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 10);
    wait_clk(BIT);
    wait_sb(0);
    chk("c3_data_out", 32'(bus0.data_out), 32'hC3);
    chk("c3_done_cnt", 32'(done_cnt0), 5);

    // Even parity: 0x3C has even weight, so parity bit 1 is a mismatch, 0 is correct
    q1.push_back('{8'h3C, 1'b1});
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, 11);
    wait_clk(BIT);
    q1.push_back('{8'h3C, 1'b0});
    send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, 11);
    wait_clk(BIT);
    wait_sb(1);
    chk("par_done_cnt", 32'(done_cnt1), 2);
    chk("par_ferr_cnt", 32'(ferr_cnt1), 0);
    chk("par_data_out", 32'(bus1.data_out), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
